// File: rtl/wb_retire_monitor_if.sv
// Write-back retire stream and retire-record handshake bundle for wb_retire_monitor.
// WB_RETIRE_MON_GAP_EN adds the rt_gap_o idle-gap field.
interface wb_retire_monitor_if;
  logic        wb_valid_i;
  logic [31:0] wb_pc_i;
  logic [31:0] wb_insn_i;
  logic        wb_we_i;
  logic [4:0]  wb_dst_i;
  logic [31:0] wb_r_i;
  logic        rt_ready_i;
  logic        rt_valid_o;
  logic [31:0] rt_seq_o;
  logic [31:0] rt_pc_o;
  logic [31:0] rt_insn_o;
  logic [31:0] rt_rs1_val_o;
  logic [31:0] rt_rs2_val_o;
  logic        rt_rd_we_o;
  logic [4:0]  rt_rd_o;
  logic [31:0] rt_rd_val_o;
  logic        rt_pc_err_o;
  logic        overflow_o;
`ifdef WB_RETIRE_MON_GAP_EN
  logic [15:0] rt_gap_o;

  modport master (
    output wb_valid_i, wb_pc_i, wb_insn_i, wb_we_i, wb_dst_i, wb_r_i, rt_ready_i,
    input  rt_valid_o, rt_seq_o, rt_pc_o, rt_insn_o, rt_rs1_val_o, rt_rs2_val_o,
           rt_rd_we_o, rt_rd_o, rt_rd_val_o, rt_pc_err_o, overflow_o, rt_gap_o
  );
  modport slave (
    input  wb_valid_i, wb_pc_i, wb_insn_i, wb_we_i, wb_dst_i, wb_r_i, rt_ready_i,
    output rt_valid_o, rt_seq_o, rt_pc_o, rt_insn_o, rt_rs1_val_o, rt_rs2_val_o,
           rt_rd_we_o, rt_rd_o, rt_rd_val_o, rt_pc_err_o, overflow_o, rt_gap_o
  );
`else
  modport master (
    output wb_valid_i, wb_pc_i, wb_insn_i, wb_we_i, wb_dst_i, wb_r_i, rt_ready_i,
    input  rt_valid_o, rt_seq_o, rt_pc_o, rt_insn_o, rt_rs1_val_o, rt_rs2_val_o,
           rt_rd_we_o, rt_rd_o, rt_rd_val_o, rt_pc_err_o, overflow_o
  );
  modport slave (
    input  wb_valid_i, wb_pc_i, wb_insn_i, wb_we_i, wb_dst_i, wb_r_i, rt_ready_i,
    output rt_valid_o, rt_seq_o, rt_pc_o, rt_insn_o, rt_rs1_val_o, rt_rs2_val_o,
           rt_rd_we_o, rt_rd_o, rt_rd_val_o, rt_pc_err_o, overflow_o
  );
`endif
endinterface

// File: rtl/wb_retire_monitor.sv
// Retire monitor: shadow RF, expected-PC tracking and a valid/ready retire-record FIFO.
// Optional idle-gap counter per record enabled by WB_RETIRE_MON_GAP_EN.
module wb_retire_monitor #(
  parameter logic [31:0] PC_INIT    = 32'h200,
  parameter int          FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  wb_retire_monitor_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] seq;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        rd_we;
    logic [4:0]  rd;
    logic [31:0] rd_val;
    logic        pc_err;
`ifdef WB_RETIRE_MON_GAP_EN
    logic [15:0] gap;
`endif
  } rec_t;

  logic [31:0] rf_rd [32];
  logic [31:0] rs1_val, rs2_val;
  logic        rd_we;
  logic [31:0] exp_pc_reg, seq_reg, next_pc;
  logic        taken;
  logic [31:0] j_imm, i_imm, b_imm;
  rec_t        rec_in, head;
  rec_t        mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic        full, rt_valid, push, pop;
  logic        overflow_reg;

  assign rd_we = bus.wb_we_i && (bus.wb_dst_i != 5'd0);

  // x0 is hard-wired; x1..x31 each get their own reset-able register
  assign rf_rd[0] = 32'd0;
  for (genvar gi = 1; gi < 32; gi++) begin : g_rf
    logic [31:0] x_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        x_reg <= 32'd0;
      else if (bus.wb_valid_i && rd_we && (bus.wb_dst_i == 5'(gi)))
        x_reg <= bus.wb_r_i;
    end
    assign rf_rd[gi] = x_reg;
  end

  assign rs1_val = rf_rd[bus.wb_insn_i[19:15]];
  assign rs2_val = rf_rd[bus.wb_insn_i[24:20]];

  assign j_imm = {{12{bus.wb_insn_i[31]}}, bus.wb_insn_i[19:12], bus.wb_insn_i[20],
                  bus.wb_insn_i[30:21], 1'b0};
  assign i_imm = {{20{bus.wb_insn_i[31]}}, bus.wb_insn_i[31:20]};
  assign b_imm = {{20{bus.wb_insn_i[31]}}, bus.wb_insn_i[7], bus.wb_insn_i[30:25],
                  bus.wb_insn_i[11:8], 1'b0};

  // Next PC derives from the retiring PC so one bad PC flags only once
  always_comb begin
    taken = 1'b0;
    case (bus.wb_insn_i[14:12])
      3'b000:  taken = (rs1_val == rs2_val);
      3'b001:  taken = (rs1_val != rs2_val);
      3'b100:  taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  taken = (rs1_val <  rs2_val);
      3'b111:  taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
    next_pc = bus.wb_pc_i + 32'd4;
    case (bus.wb_insn_i[6:0])
      7'b1101111: next_pc = bus.wb_pc_i + j_imm;
      7'b1100111: next_pc = (rs1_val + i_imm) & ~32'd1;
      7'b1100011: next_pc = taken ? (bus.wb_pc_i + b_imm) : (bus.wb_pc_i + 32'd4);
      default:    next_pc = bus.wb_pc_i + 32'd4;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_pc_reg <= PC_INIT;
      seq_reg    <= 32'd0;
    end else if (bus.wb_valid_i) begin
      exp_pc_reg <= next_pc;
      seq_reg    <= seq_reg + 32'd1;
    end
  end

`ifdef WB_RETIRE_MON_GAP_EN
  logic [15:0] gap_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      gap_reg <= 16'd0;
    else if (bus.wb_valid_i)
      gap_reg <= 16'd0;
    else if (gap_reg != 16'hFFFF)
      gap_reg <= gap_reg + 16'd1;
  end
  assign rec_in.gap = gap_reg;
  assign bus.rt_gap_o = rt_valid ? head.gap : 16'd0;
`endif

  assign rec_in.seq    = seq_reg;
  assign rec_in.pc     = bus.wb_pc_i;
  assign rec_in.insn   = bus.wb_insn_i;
  assign rec_in.rs1    = rs1_val;
  assign rec_in.rs2    = rs2_val;
  assign rec_in.rd_we  = rd_we;
  assign rec_in.rd     = bus.wb_dst_i;
  assign rec_in.rd_val = bus.wb_r_i;
  assign rec_in.pc_err = (bus.wb_pc_i != exp_pc_reg);

  assign rt_valid = (count_reg != '0);
  assign full     = (count_reg == DEPTH_C);
  assign pop      = rt_valid && bus.rt_ready_i;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign push     = bus.wb_valid_i && (!full || pop);

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= rec_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)
        count_reg <= count_reg + 1'b1;
      else if (pop && !push)
        count_reg <= count_reg - 1'b1;
      if (bus.wb_valid_i && !push)
        overflow_reg <= 1'b1;
    end
  end

  assign head = mem[rd_ptr_reg];

  assign bus.rt_valid_o   = rt_valid;
  assign bus.rt_seq_o     = rt_valid ? head.seq    : 32'd0;
  assign bus.rt_pc_o      = rt_valid ? head.pc     : 32'd0;
  assign bus.rt_insn_o    = rt_valid ? head.insn   : 32'd0;
  assign bus.rt_rs1_val_o = rt_valid ? head.rs1    : 32'd0;
  assign bus.rt_rs2_val_o = rt_valid ? head.rs2    : 32'd0;
  assign bus.rt_rd_we_o   = rt_valid ? head.rd_we  : 1'b0;
  assign bus.rt_rd_o      = rt_valid ? head.rd     : 5'd0;
  assign bus.rt_rd_val_o  = rt_valid ? head.rd_val : 32'd0;
  assign bus.rt_pc_err_o  = rt_valid ? head.pc_err : 1'b0;
  assign bus.overflow_o   = overflow_reg;
endmodule
